rpn_token_sequencer: RTL
========================

// Module: rpn_token_sequencer
// PURPOSE
//  Upstream command stage for the stack ALU. It accepts a stream of RPN tokens (operands and
//  ADD/MUL operators) over valid/ready and turns them into timed PUSH/ADD/MUL/POP opcodes.
//  It folds each operator result back onto the ALU stack and pops the final value as one
//  result per expression (token with tok_last).
// PARAMETERS
//  N      16   operand/result width, two's complement; must equal the ALU's N
//  DEPTH  512  ALU stack capacity in entries
//  DW     10   width of the internal depth counter; must hold 0..DEPTH
// PORTS
//  clk           in   1   single clock, rising edge
//  rst_n         in   1   asynchronous, active-low reset
//  tok_valid     in   1   token present
//  tok_ready     out  1   block can accept a token this cycle
//  tok_kind      in   1   0 = operand, 1 = operator
//  tok_op        in   1   operator select: 0 = ADD, 1 = MUL (ignored for operands)
//  tok_data      in   N   operand value, signed
//  tok_last      in   1   last token of the expression
//  alu_opcode    out  3   registered; the ALU executes it at the next edge
//  alu_data      out  N   registered; ALU input_data, meaningful with PUSH only
//  alu_result    in   N   ALU output_data
//  alu_overflow  in   1   ALU overflow
//  res_valid     out  1   one-cycle pulse: result fields are valid
//  res_data      out  N   final expression value (0 on empty stack)
//  res_overflow  out  1   sticky: some ADD/MUL in the expression overflowed
//  res_error     out  1   sticky: underflow, stack full, or final depth != 1
//  busy          out  1   high in any state other than IDLE
// BEHAVIOUR
//  Reset values
//   - tok_ready=0 during reset, 1 from the first edge after release.
//   - alu_opcode=NOP(000), alu_data=0, res_*=0, busy=0, depth=0, state=IDLE.
//  Opcodes
//   - NOP=000, ADD=100, MUL=101, PUSH=110, POP=111.
//   - Any cycle not listed below drives NOP.
//  Handshake
//   - A token is accepted at an edge where tok_valid && tok_ready.
//   - tok_ready = (state==IDLE). It is combinational from state.
//  Operand (IDLE)
//   - Accept edge a: alu_opcode<=PUSH, alu_data<=tok_data, depth++.
//   - Stays in IDLE, so back-to-back operands run 1 per cycle.
//   - depth==DEPTH: no PUSH, error<=1, token dropped.
//  Operator, depth>=2 (edges relative to accept edge a)
//   - a: ADD/MUL
//   - a+1: POP
//   - a+2: tmp<=alu_result, ovf|=alu_overflow; issue POP
//   - a+3: PUSH tmp, depth--
//   - a+4: NOP, back to IDLE
//   - States: IDLE -> OP -> POP1 -> POP2 -> PUSHR -> IDLE; tok_ready is low for 4 cycles.
//  Operator, depth<2
//   - Token consumed, error<=1, no ALU command, stays in IDLE.
//  tok_last
//   - Applied after the token's own sequence completes.
//   - depth==0: res_data=0, error=1, res_valid pulse on the next edge.
//   - depth>=1: FINAL_POP issues POP at edge f; at f+2 res_data<=alu_result and depth--.
//   - If depth was >1: error<=1 and DRAIN issues POP, one per cycle, until depth==0.
//   - res_valid pulses for one cycle at the end, with res_overflow/res_error.
//   - Sticky flags clear on the edge after res_valid. Return to IDLE.
//  Other rules
//   - Arithmetic stays in the ALU. The sum/product is captured exactly as N bits.
//   - Reset mid-expression abandons it; ALU stack entries are not reclaimed. The top level
//     must reset the ALU together with this block.
// STRUCTURE
//  - Package rpn_pkg: opcode localparams, TOK_OPERAND/TOK_OPERATOR, OP_ADD/OP_MUL, state enum
//    encoding.
//  - Sub-module rpn_depth_counter: inc/dec/clear, full/empty/ge2 flags, async reset.
//  - FSM, tmp register and result registers stay in this module.
// TESTING (bench uses a behavioural ALU model with the same opcode timing)
//  - 3, 4, +(last) -> PUSH,PUSH,ADD,POP,POP,PUSH,POP; res_data=7, ovf=0, err=0.
//  - 3, 4, *, 5, +(last) -> res_data=17; tok_ready low exactly 4 cycles per operator.
//  - N=16: 30000, 30000, +(last) -> res_data=-5536, res_overflow=1.
//  - +(last) alone -> no ALU command, res_error=1, res_data=0; then 2, 2, *(last) -> 4 with
//    flags clear.
//  - 1, 2(last) -> res_data=2, res_error=1, one DRAIN POP, busy falls afterward.
//  - rst_n low during POP2 -> all outputs at reset values in the same cycle; tok_ready
//    returns to 1 after release.

Source files
------------

// File: rtl/rpn_pkg.sv
// Shared opcodes, token encodings and FSM state type for the RPN token sequencer.
package rpn_pkg;

    localparam logic [2:0] OPC_NOP  = 3'b000;
    localparam logic [2:0] OPC_ADD  = 3'b100;
    localparam logic [2:0] OPC_MUL  = 3'b101;
    localparam logic [2:0] OPC_PUSH = 3'b110;
    localparam logic [2:0] OPC_POP  = 3'b111;

    localparam logic TOK_OPERAND  = 1'b0;
    localparam logic TOK_OPERATOR = 1'b1;
    localparam logic OP_ADD       = 1'b0;
    localparam logic OP_MUL       = 1'b1;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_OP        = 4'd1,
        ST_POP1      = 4'd2,
        ST_POP2      = 4'd3,
        ST_PUSHR     = 4'd4,
        ST_FINAL_POP = 4'd5,
        ST_FWAIT     = 4'd6,
        ST_FCAP      = 4'd7,
        ST_DRAIN     = 4'd8,
        ST_DONE      = 4'd9
    } state_e;

    // Map an operator token select onto the ALU arithmetic opcode.
    function automatic logic [2:0] op_to_opcode(input logic op);
        return (op == OP_MUL) ? OPC_MUL : OPC_ADD;
    endfunction

endpackage

// File: rtl/rpn_token_sequencer_if.sv
// Token stream handshake between the token producer and the sequencer.
interface rpn_token_sequencer_if #(parameter int N = 16);
    logic         tok_valid;
    logic         tok_ready;
    logic         tok_kind;
    logic         tok_op;
    logic [N-1:0] tok_data;
    logic         tok_last;

    modport master (output tok_valid, output tok_kind, output tok_op,
                    output tok_data, output tok_last, input tok_ready);
    modport slave  (input tok_valid, input tok_kind, input tok_op,
                    input tok_data, input tok_last, output tok_ready);
endinterface

// File: rtl/rpn_depth_counter.sv
// Tracks how many entries the ALU stack currently holds.
module rpn_depth_counter #(
    parameter int DEPTH = 512,
    parameter int DW    = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_inc,
    input  logic          i_dec,
    input  logic          i_clr,
    output logic [DW-1:0] o_depth,
    output logic          o_full,
    output logic          o_empty,
    output logic          o_ge2
);

    logic [DW-1:0] r_depth;

    // Depth register: clear has priority, simultaneous inc/dec cancel out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_depth <= {DW{1'b0}};
        end else if (i_clr) begin
            r_depth <= {DW{1'b0}};
        end else if (i_inc && !i_dec) begin
            r_depth <= r_depth + DW'(1);
        end else if (i_dec && !i_inc) begin
            r_depth <= r_depth - DW'(1);
        end else begin
            r_depth <= r_depth;
        end
    end

    assign o_depth = r_depth;
    assign o_full  = (r_depth == DW'(DEPTH));
    assign o_empty = (r_depth == {DW{1'b0}});
    assign o_ge2   = (r_depth >= DW'(2));

endmodule

// File: rtl/rpn_token_sequencer.sv
// Turns RPN tokens into timed PUSH/ADD/MUL/POP commands for the stack ALU and
// reports one result per expression.
module rpn_token_sequencer
    import rpn_pkg::*;
#(
    parameter int N     = 16,
    parameter int DEPTH = 512,
    parameter int DW    = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    rpn_token_sequencer_if.slave  tok,
    output logic [2:0]            o_alu_opcode,
    output logic [N-1:0]          o_alu_data,
    input  logic [N-1:0]          i_alu_result,
    input  logic                  i_alu_overflow,
    output logic                  o_res_valid,
    output logic [N-1:0]          o_res_data,
    output logic                  o_res_overflow,
    output logic                  o_res_error,
    output logic                  o_busy
);

    state_e         r_state, w_state_nxt;
    logic [2:0]     r_alu_opcode, w_opc_nxt;
    logic [N-1:0]   r_alu_data, w_data_nxt;
    logic [N-1:0]   r_tmp, w_tmp_nxt;
    logic [N-1:0]   r_res_data, w_res_data_nxt;
    logic           r_ovf, w_ovf_nxt;
    logic           r_err, w_err_nxt;
    logic           r_last, w_last_nxt;
    logic           r_res_valid, w_res_valid_nxt;
    logic           r_res_ovf, w_res_ovf_nxt;
    logic           r_res_err, w_res_err_nxt;
    logic           r_busy;
    logic           r_started;
    logic           w_accept, w_inc, w_dec;
    logic           w_full, w_empty, w_ge2;
    logic [DW-1:0]  w_depth;

    rpn_depth_counter #(.DEPTH(DEPTH), .DW(DW)) u_depth (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_inc   (w_inc),
        .i_dec   (w_dec),
        .i_clr   (1'b0),
        .o_depth (w_depth),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_ge2   (w_ge2)
    );

    // Ready only in IDLE and only once reset has been released for an edge.
    assign tok.tok_ready = r_started && (r_state == ST_IDLE);
    assign w_accept      = tok.tok_valid && tok.tok_ready;

    // Next-state and next-output decode for the command sequencer.
    always_comb begin
        w_state_nxt     = r_state;
        w_opc_nxt       = OPC_NOP;
        w_data_nxt      = r_alu_data;
        w_tmp_nxt       = r_tmp;
        w_ovf_nxt       = r_ovf;
        w_err_nxt       = r_err;
        w_last_nxt      = r_last;
        w_res_valid_nxt = 1'b0;
        w_res_data_nxt  = r_res_data;
        w_res_ovf_nxt   = 1'b0;
        w_res_err_nxt   = 1'b0;
        w_inc           = 1'b0;
        w_dec           = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (tok.tok_kind == TOK_OPERAND) begin
                        if (w_full) begin
                            w_err_nxt = 1'b1;
                        end else begin
                            w_opc_nxt  = OPC_PUSH;
                            w_data_nxt = tok.tok_data;
                            w_inc      = 1'b1;
                        end
                        w_state_nxt = tok.tok_last ? ST_FINAL_POP : ST_IDLE;
                    end else if (w_ge2) begin
                        w_opc_nxt   = op_to_opcode(tok.tok_op);
                        w_last_nxt  = tok.tok_last;
                        w_state_nxt = ST_OP;
                    end else begin
                        // Operator underflow: consume it without touching the ALU.
                        w_err_nxt   = 1'b1;
                        w_state_nxt = tok.tok_last ? ST_FINAL_POP : ST_IDLE;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_OP: begin
                w_opc_nxt   = OPC_POP;
                w_state_nxt = ST_POP1;
            end
            ST_POP1: begin
                // ALU output now holds the sum/product computed on the previous edge.
                w_tmp_nxt   = i_alu_result;
                w_ovf_nxt   = r_ovf | i_alu_overflow;
                w_opc_nxt   = OPC_POP;
                w_state_nxt = ST_POP2;
            end
            ST_POP2: begin
                w_opc_nxt   = OPC_PUSH;
                w_data_nxt  = r_tmp;
                w_dec       = 1'b1;
                w_state_nxt = ST_PUSHR;
            end
            ST_PUSHR: begin
                w_last_nxt  = 1'b0;
                w_state_nxt = r_last ? ST_FINAL_POP : ST_IDLE;
            end
            ST_FINAL_POP: begin
                if (w_empty) begin
                    w_res_valid_nxt = 1'b1;
                    w_res_data_nxt  = {N{1'b0}};
                    w_res_ovf_nxt   = r_ovf;
                    w_res_err_nxt   = 1'b1;
                    w_ovf_nxt       = 1'b0;
                    w_err_nxt       = 1'b0;
                    w_state_nxt     = ST_IDLE;
                end else begin
                    w_opc_nxt   = OPC_POP;
                    w_state_nxt = ST_FWAIT;
                end
            end
            ST_FWAIT: begin
                w_state_nxt = ST_FCAP;
            end
            ST_FCAP: begin
                w_res_data_nxt = i_alu_result;
                w_dec          = 1'b1;
                if (w_ge2) begin
                    // Leftover operands: flag the expression and empty the ALU stack.
                    w_err_nxt   = 1'b1;
                    w_state_nxt = ST_DRAIN;
                end else begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DRAIN: begin
                w_opc_nxt = OPC_POP;
                w_dec     = 1'b1;
                if (w_depth == DW'(1)) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DONE: begin
                w_res_valid_nxt = 1'b1;
                w_res_ovf_nxt   = r_ovf;
                w_res_err_nxt   = r_err;
                w_ovf_nxt       = 1'b0;
                w_err_nxt       = 1'b0;
                w_state_nxt     = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, command and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_alu_opcode <= OPC_NOP;
            r_alu_data   <= {N{1'b0}};
            r_tmp        <= {N{1'b0}};
            r_ovf        <= 1'b0;
            r_err        <= 1'b0;
            r_last       <= 1'b0;
            r_res_valid  <= 1'b0;
            r_res_data   <= {N{1'b0}};
            r_res_ovf    <= 1'b0;
            r_res_err    <= 1'b0;
            r_busy       <= 1'b0;
            r_started    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_alu_opcode <= w_opc_nxt;
            r_alu_data   <= w_data_nxt;
            r_tmp        <= w_tmp_nxt;
            r_ovf        <= w_ovf_nxt;
            r_err        <= w_err_nxt;
            r_last       <= w_last_nxt;
            r_res_valid  <= w_res_valid_nxt;
            r_res_data   <= w_res_data_nxt;
            r_res_ovf    <= w_res_ovf_nxt;
            r_res_err    <= w_res_err_nxt;
            r_busy       <= (w_state_nxt != ST_IDLE);
            r_started    <= 1'b1;
        end
    end

    assign o_alu_opcode   = r_alu_opcode;
    assign o_alu_data     = r_alu_data;
    assign o_res_valid    = r_res_valid;
    assign o_res_data     = r_res_data;
    assign o_res_overflow = r_res_ovf;
    assign o_res_error    = r_res_err;
    assign o_busy         = r_busy;

endmodule
